// File: rtl/quad_updown_decoder.sv
// quad_updown_decoder
//   x4 quadrature decoder. Phases A/B are synchronized, then each cycle the
//   synchronized pair is compared with the pair from the previous cycle. A legal
//   Gray step moves Count up or down. A change in both bits at once is flagged
//   as an error. Every output is registered.
//
// Ports
//   Clk       system clock; all logic on the rising edge
//   reset     synchronous active-low reset
//   A, B      encoder phases, asynchronous to Clk
//   clr       synchronous clear of Count and err_flag (active high)
//   Count     wrapping position count, WIDTH bits
//   UpOrDown  direction of the last legal step (1 = up)
//   step      one-cycle pulse per legal step
//   err       one-cycle pulse per illegal transition
//   err_flag  sticky error, cleared by clr or reset

module quad_updown_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    input  logic             clr,
    output logic [WIDTH-1:0] Count,
    output logic             UpOrDown,
    output logic             step,
    output logic             err,
    output logic             err_flag
);

    localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1);
    localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SYNC_STAGES);

    typedef enum logic [0:0] {StPrime, StRun} state_e;

    state_e             state_q, state_d;
    logic [PrimeW-1:0]  prime_cnt_q, prime_cnt_d;
    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]         ab_s;
    logic [1:0]         prev_ab_q;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               err_q, err_d;
    logic               flag_q, flag_d;
    logic               is_up, is_dn, is_bad;

    assign ab_s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    // Classify {previous, current} phase pair. Up order is 00->01->11->10->00.
    always_comb begin
        is_up  = 1'b0;
        is_dn  = 1'b0;
        is_bad = 1'b0;
        case ({prev_ab_q, ab_s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up  = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_bad = 1'b1;
            default: ;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        count_d     = count_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
        flag_d      = flag_q;

        unique case (state_q)
            StPrime: begin
                // Hold off decoding until the synchronizer and prev_ab carry
                // real pin values, so the value at reset release is absorbed.
                if (prime_cnt_q == PrimeLast) begin
                    state_d     = StRun;
                    prime_cnt_d = '0;
                end else begin
                    prime_cnt_d = prime_cnt_q + PrimeW'(1);
                end
            end
            StRun: begin
                if (is_up) begin
                    count_d = count_q + WIDTH'(1);
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end else if (is_dn) begin
                    count_d = count_q - WIDTH'(1);
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end else if (is_bad) begin
                    err_d  = 1'b1;
                    flag_d = 1'b1;
                end
            end
            default: state_d = StPrime;
        endcase

        // clr overrides only the count and the sticky flag; pulses and
        // direction still report what was decoded.
        if (clr) begin
            count_d = '0;
            flag_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q     <= StPrime;
            prime_cnt_q <= '0;
            a_sync_q    <= '0;
            b_sync_q    <= '0;
            prev_ab_q   <= 2'b00;
            count_q     <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            a_sync_q    <= {a_sync_q[SYNC_STAGES-2:0], A};
            b_sync_q    <= {b_sync_q[SYNC_STAGES-2:0], B};
            prev_ab_q   <= ab_s;
            count_q     <= count_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            flag_q      <= flag_d;
        end
    end

    assign Count    = count_q;
    assign UpOrDown = dir_q;
    assign step     = step_q;
    assign err      = err_q;
    assign err_flag = flag_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Bench for quad_updown_decoder. The encoder is modelled as a shaft position:
// a phase index 0..3 picks the Gray pair on A/B. The expected count is the
// signed sum of moves modulo 2^WIDTH. Step and err pulses are tallied by a
// monitor and compared with the number of moves the model made.

module tb_quad_updown_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int          MOD   = 2 ** WIDTH;

    logic             Clk = 1'b0;
    logic             reset = 1'b0;
    logic             A = 1'b0;
    logic             B = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] Count;
    logic             UpOrDown;
    logic             step;
    logic             err;
    logic             err_flag;

    quad_updown_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .clr     (clr),
        .Count   (Count),
        .UpOrDown(UpOrDown),
        .step    (step),
        .err     (err),
        .err_flag(err_flag)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse tally from the DUT outputs
    int step_cnt = 0;
    int err_cnt  = 0;
    always @(posedge Clk) begin
        if (step === 1'b1) step_cnt <= step_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    // Reference model state
    int   phase     = 0;
    int   exp_count = 0;
    logic exp_dir   = 1'b0;
    logic exp_flag  = 1'b0;
    int   exp_steps = 0;
    int   exp_errs  = 0;

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Turn the shaft by d quarter-phases (+1 up, -1 down, +2 illegal jump)
    // and update the model; then let the change settle through the decoder.
    task automatic move(input int d);
        @(negedge Clk);
        phase  = (phase + d + 4) % 4;
        {A, B} = ab_of(phase);
        if (d == 1) begin
            exp_count = (exp_count + 1) % MOD;
            exp_dir   = 1'b1;
            exp_steps++;
        end else if (d == -1) begin
            exp_count = (exp_count + MOD - 1) % MOD;
            exp_dir   = 1'b0;
            exp_steps++;
        end else begin
            exp_flag = 1'b1;
            exp_errs++;
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic apply_reset(input int cycles, input logic [1:0] pins);
        @(negedge Clk);
        reset  = 1'b0;
        clr    = 1'b0;
        {A, B} = pins;
        phase  = phase_of(pins);
        repeat (cycles) @(negedge Clk);
        reset     = 1'b1;
        exp_count = 0;
        exp_dir   = 1'b0;
        exp_flag  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        reset  = 1'b0;
        {A, B} = 2'b00;
        phase  = 0;
        repeat (3) @(negedge Clk);
        n_tests++;
        if (Count !== '0 || UpOrDown !== 1'b0 || step !== 1'b0 || err !== 1'b0 ||
            err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got Count=%0d dir=%b step=%b err=%b flag=%b want all 0",
                     Count, UpOrDown, step, err, err_flag);
        end
        reset = 1'b1;
        repeat (10) @(negedge Clk);
        n_tests++;
        if (Count !== '0 || UpOrDown !== 1'b0 || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got Count=%0d dir=%b flag=%b want 0 0 0",
                     Count, UpOrDown, err_flag);
        end
        n_tests++;
        if (step_cnt != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_no_pulses: got steps=%0d errs=%0d want 0 0", step_cnt, err_cnt);
        end
    endtask

    task automatic test_up();
        logic want_step;
        // First step: pulse appears exactly SYNC+1 edges after the pin change
        @(negedge Clk);
        phase  = 1;
        {A, B} = ab_of(phase);
        exp_count = (exp_count + 1) % MOD;
        exp_dir   = 1'b1;
        exp_steps++;
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk);
            #1;
            want_step = (i == SYNC + 1);
            n_tests++;
            if (step !== want_step) begin
                n_fail++;
                $display("FAIL up_latency edge %0d: got step=%b want %b", i, step, want_step);
            end
        end
        @(negedge Clk);
        for (int i = 0; i < 7; i++) move(1);
        n_tests++;
        if (Count !== WIDTH'(exp_count) || exp_count != 8) begin
            n_fail++;
            $display("FAIL up_count: got %0d want %0d (8)", Count, exp_count);
        end
        n_tests++;
        if (UpOrDown !== 1'b1 || step_cnt != exp_steps || err_cnt != exp_errs) begin
            n_fail++;
            $display("FAIL up_pulses: got dir=%b steps=%0d errs=%0d want 1 %0d %0d",
                     UpOrDown, step_cnt, err_cnt, exp_steps, exp_errs);
        end
    endtask

    task automatic test_down_wrap();
        apply_reset(2, 2'b00);
        move(1);
        for (int i = 0; i < 3; i++) begin
            move(-1);
            n_tests++;
            if (Count !== WIDTH'(exp_count) || UpOrDown !== 1'b0) begin
                n_fail++;
                $display("FAIL down_wrap step %0d: got Count=%0d dir=%b want %0d 0",
                         i, Count, UpOrDown, exp_count);
            end
        end
        n_tests++;
        if (Count !== 4'd14 || err_cnt != exp_errs || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL down_end: got Count=%0d errs=%0d flag=%b want 14 %0d 0",
                     Count, err_cnt, err_flag, exp_errs);
        end
    endtask

    task automatic test_illegal_clr();
        apply_reset(3, 2'b11);
        repeat (6) @(negedge Clk);
        n_tests++;
        if (Count !== '0 || step_cnt != exp_steps || err_cnt != exp_errs) begin
            n_fail++;
            $display("FAIL prime_absorb_11: got Count=%0d steps=%0d errs=%0d want 0 %0d %0d",
                     Count, step_cnt, err_cnt, exp_steps, exp_errs);
        end
        move(1);
        move(2);
        n_tests++;
        if (err_cnt != exp_errs || err_flag !== 1'b1 || Count !== WIDTH'(exp_count)) begin
            n_fail++;
            $display("FAIL illegal: got errs=%0d flag=%b Count=%0d want %0d 1 %0d",
                     err_cnt, err_flag, Count, exp_errs, exp_count);
        end
        @(negedge Clk);
        clr = 1'b1;
        @(negedge Clk);
        clr       = 1'b0;
        exp_count = 0;
        exp_flag  = 1'b0;
        n_tests++;
        if (Count !== '0 || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clr: got Count=%0d flag=%b want 0 0", Count, err_flag);
        end
    endtask

    task automatic test_clr_step();
        move(1);
        move(1);
        @(negedge Clk);
        phase  = (phase + 1) % 4;
        {A, B} = ab_of(phase);
        exp_dir   = 1'b1;
        exp_steps++;
        exp_count = 0;
        repeat (SYNC) @(negedge Clk);
        clr = 1'b1;
        @(posedge Clk);
        #1;
        n_tests++;
        if (step !== 1'b1 || UpOrDown !== 1'b1 || Count !== '0) begin
            n_fail++;
            $display("FAIL clr_vs_step: got step=%b dir=%b Count=%0d want 1 1 0",
                     step, UpOrDown, Count);
        end
        @(negedge Clk);
        clr = 1'b0;
        repeat (2) @(negedge Clk);
        n_tests++;
        if (Count !== '0 || step_cnt != exp_steps) begin
            n_fail++;
            $display("FAIL clr_vs_step_after: got Count=%0d steps=%0d want 0 %0d",
                     Count, step_cnt, exp_steps);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2, 2'b00);
        for (int i = 0; i < 5; i++) move(1);
        move(2);
        n_tests++;
        if (Count !== 4'd5 || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got Count=%0d flag=%b want 5 1", Count, err_flag);
        end
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        exp_count = 0;
        exp_dir   = 1'b0;
        exp_flag  = 1'b0;
        n_tests++;
        if (Count !== '0 || err_flag !== 1'b0 || UpOrDown !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got Count=%0d flag=%b dir=%b want 0 0 0",
                     Count, err_flag, UpOrDown);
        end
        reset = 1'b1;
        repeat (6) @(negedge Clk);
        n_tests++;
        if (Count !== '0 || step_cnt != exp_steps || err_cnt != exp_errs) begin
            n_fail++;
            $display("FAIL mid_prime: got Count=%0d steps=%0d errs=%0d want 0 %0d %0d",
                     Count, step_cnt, err_cnt, exp_steps, exp_errs);
        end
        move(1);
        n_tests++;
        if (Count !== 4'd1 || UpOrDown !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after: got Count=%0d dir=%b want 1 1", Count, UpOrDown);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) move(2);
            else if (r < 5) move(1);
            else move(-1);
            n_tests++;
            if (Count !== WIDTH'(exp_count) || UpOrDown !== exp_dir ||
                err_flag !== exp_flag) begin
                n_fail++;
                $display("FAIL random %0d: got Count=%0d dir=%b flag=%b want %0d %b %b",
                         i, Count, UpOrDown, err_flag, exp_count, exp_dir, exp_flag);
            end
            n_tests++;
            if (step_cnt != exp_steps || err_cnt != exp_errs) begin
                n_fail++;
                $display("FAIL random_pulses %0d: got steps=%0d errs=%0d want %0d %0d",
                         i, step_cnt, err_cnt, exp_steps, exp_errs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_illegal_clr();
        test_clr_step();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
